fila_de_instrucoes_bufferizada: RTL and testbench

Parametrised instruction-fetch queue for the processor front end. Streams sequential instruction words from a synchronous-read instruction ROM into an internal FIFO at up to one word per cycle. Hands them to the decoder over a valid/consume handshake, and supports a branch redirect that flushes the queue. Sits between the instruction ROM (instantiated outside this block) and the control/decode stage.

---
 rtl/fila_pkg.sv | 24 ++
 rtl/fifo_sincrona.sv | 92 +++++++++
 rtl/fila_de_instrucoes_bufferizada.sv | 116 +++++++++++
 tb/tb_fila_de_instrucoes_bufferizada.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fila_pkg
// Purpose  : Shared constants and entry layout for the instruction-fetch
//            queue. The defaults feed the parameters of the top module.
//            Entries are packed as {addr, word}, with addr in the upper bits.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package fila_pkg;

  localparam int FILA_DATA_W = 16;
  localparam int FILA_ADDR_W = 4;
  localparam int FILA_DEPTH  = 4;

  // Queue entry at the default widths. The top module packs entries the same
  // way ({addr, word}) for any parameter set.
  typedef struct packed {
    logic [FILA_ADDR_W-1:0] addr;
    logic [FILA_DATA_W-1:0] word;
  } fila_entrada_t;

endpackage : fila_pkg
`default_nettype wire

// File: rtl/fifo_sincrona.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sincrona
// Purpose  : Generic synchronous FIFO with a registered read-data output
//            (the head entry is read directly from storage registers).
// Ports    : clk, rst   - clock, synchronous active-high reset
//            clear      - empties the FIFO; takes priority over push and pop
//            push, din  - write an entry; ignored when full without a pop
//            pop        - remove the head entry; ignored when empty
//            dout       - head entry (stale contents when count == 0)
//            count      - number of stored entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sincrona #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_ok_w;
  logic pop_ok_w;

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign pop_ok_w  = pop && (count_q != '0);
  assign push_ok_w = push && ((count_q != C_DEPTH) || pop_ok_w);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_w) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_w) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok_w && !pop_ok_w) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_ok_w && !push_ok_w) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : fifo_sincrona
`default_nettype wire

// File: rtl/fila_de_instrucoes_bufferizada.sv
`default_nettype none
// ============================================================================
// Module   : fila_de_instrucoes_bufferizada
// Purpose  : Instruction-fetch queue. Streams sequential words from a
//            synchronous-read ROM into a FIFO (one per cycle at most), hands
//            them to the decoder on a valid/consume handshake and flushes on
//            a branch redirect.
// Ports    : Clock, Reset      - clock, synchronous active-high reset
//            MemEndereco       - ROM address (the PC register)
//            MemDado           - ROM data, valid one cycle after the address
//            Desvio            - redirect pulse; overrides everything else
//            EnderecoDesvio    - redirect target
//            Consumir          - decoder pops the head entry
//            Instrucao         - head word (0 when empty)
//            PCInstrucao       - head address (0 when empty)
//            InstrucaoValida   - queue not empty
//            Ocupacao          - number of queued entries
// Revision : 1.0 - initial release
// ============================================================================
module fila_de_instrucoes_bufferizada
  import fila_pkg::*;
#(
  parameter int DATA_W = FILA_DATA_W,
  parameter int ADDR_W = FILA_ADDR_W,
  parameter int DEPTH  = FILA_DEPTH
) (
  input  logic                       Clock,
  input  logic                       Reset,
  output logic [ADDR_W-1:0]          MemEndereco,
  input  logic [DATA_W-1:0]          MemDado,
  input  logic                       Desvio,
  input  logic [ADDR_W-1:0]          EnderecoDesvio,
  input  logic                       Consumir,
  output logic [DATA_W-1:0]          Instrucao,
  output logic [ADDR_W-1:0]          PCInstrucao,
  output logic                       InstrucaoValida,
  output logic [$clog2(DEPTH+1)-1:0] Ocupacao
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [OCC_W:0] C_DEPTH = (OCC_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pendente_q, pendente_d;
  logic [ADDR_W-1:0] tag_q, tag_d;

  logic [OCC_W:0]    credito_w;
  logic              emite_w;
  logic              push_w;
  logic              pop_w;
  logic [ENT_W-1:0]  entrada_w;
  logic [ENT_W-1:0]  cabeca_w;
  logic [OCC_W-1:0]  ocupacao_w;
  logic              valida_w;

  // Credit counts queued entries plus the read in flight; a same-cycle pop
  // is deliberately not credited, so the queue can never overflow.
  assign credito_w = {1'b0, ocupacao_w} + {{OCC_W{1'b0}}, pendente_q};
  assign emite_w   = !Desvio && (credito_w < C_DEPTH);
  assign valida_w  = (ocupacao_w != '0);

  // The ROM word arriving now belongs to the address captured in tag_q.
  assign push_w    = pendente_q && !Desvio;
  assign pop_w     = Consumir && valida_w && !Desvio;
  assign entrada_w = {tag_q, MemDado};

  always_comb begin
    pc_d       = pc_q;
    pendente_d = 1'b0;
    tag_d      = tag_q;
    if (Desvio) begin
      pc_d = EnderecoDesvio;
    end else if (emite_w) begin
      pendente_d = 1'b1;
      tag_d      = pc_q;
      pc_d       = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q       <= '0;
      pendente_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pendente_q <= pendente_d;
      tag_q      <= tag_d;
    end
  end

  fifo_sincrona #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .clear (Desvio),
    .push  (push_w),
    .pop   (pop_w),
    .din   (entrada_w),
    .dout  (cabeca_w),
    .count (ocupacao_w)
  );

  // Head fields come straight from FIFO registers, masked by the registered
  // count, so neither Consumir nor Desvio reaches these outputs combinationally.
  assign MemEndereco     = pc_q;
  assign Instrucao       = valida_w ? cabeca_w[DATA_W-1:0] : '0;
  assign PCInstrucao     = valida_w ? cabeca_w[ENT_W-1:DATA_W] : '0;
  assign InstrucaoValida = valida_w;
  assign Ocupacao        = ocupacao_w;

endmodule : fila_de_instrucoes_bufferizada
`default_nettype wire

// File: tb/tb_fila_de_instrucoes_bufferizada.sv
`default_nettype none
// ============================================================================
// Module   : tb_fila_de_instrucoes_bufferizada
// Purpose  : Self-checking bench for the instruction-fetch queue, with a
//            queue-based reference model, a ROM model returning 0xA000+addr,
//            directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fila_de_instrucoes_bufferizada;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int OCC_W  = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_dado;
  logic              desvio;
  logic [ADDR_W-1:0] endereco_desvio;
  logic              consumir;
  logic [DATA_W-1:0] instrucao;
  logic [ADDR_W-1:0] pc_instrucao;
  logic              instrucao_valida;
  logic [OCC_W-1:0]  ocupacao;

  int n_cmp = 0;
  int n_bad = 0;
  bit en_cmp = 0;

  fila_de_instrucoes_bufferizada #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .Clock           (clk),
    .Reset           (rst),
    .MemEndereco     (mem_endereco),
    .MemDado         (mem_dado),
    .Desvio          (desvio),
    .EnderecoDesvio  (endereco_desvio),
    .Consumir        (consumir),
    .Instrucao       (instrucao),
    .PCInstrucao     (pc_instrucao),
    .InstrucaoValida (instrucao_valida),
    .Ocupacao        (ocupacao)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM: data for the address presented one cycle earlier.
  always @(posedge clk) mem_dado <= 16'hA000 + {12'h000, mem_endereco};

  // Reference model: PC, one in-flight read, and a queue of {addr, word}.
  int m_pc = 0;
  bit m_pend = 0;
  int m_tag = 0;
  int m_addr[$];
  int m_word[$];

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_pend = 0; m_tag = 0;
      m_addr.delete(); m_word.delete();
    end else if (desvio) begin
      m_addr.delete(); m_word.delete();
      m_pend = 0;
      m_pc   = int'(endereco_desvio);
    end else begin
      bit issue;
      issue = (m_addr.size() + int'(m_pend)) < DEPTH;
      if (consumir && m_addr.size() > 0) begin
        void'(m_addr.pop_front()); void'(m_word.pop_front());
      end
      if (m_pend) begin
        m_addr.push_back(m_tag);
        m_word.push_back('hA000 + m_tag);
      end
      if (issue) begin
        m_pend = 1;
        m_tag  = m_pc;
        m_pc   = (m_pc + 1) % (1 << ADDR_W);
      end else begin
        m_pend = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (en_cmp) begin
      int sz;
      sz = m_addr.size();
      chk("mem_endereco", 32'(mem_endereco), 32'(m_pc));
      chk("ocupacao", 32'(ocupacao), 32'(sz));
      chk("valida", 32'(instrucao_valida), 32'(sz > 0));
      chk("instrucao", 32'(instrucao), (sz > 0) ? 32'(m_word[0]) : 32'h0);
      chk("pc_instrucao", 32'(pc_instrucao), (sz > 0) ? 32'(m_addr[0]) : 32'h0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; desvio = 1'b0; endereco_desvio = '0; consumir = 1'b0;
    repeat (3) step();
    en_cmp = 1;

    // Sustained streaming from reset, including PC wrap 15 -> 0.
    rst = 1'b0; consumir = 1'b1;
    step();
    chk("lit_valid_cycle1", 32'(instrucao_valida), 32'h0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("lit_stream_valid", 32'(instrucao_valida), 32'h1);
      chk("lit_stream_pc", 32'(pc_instrucao), 32'(k % 16));
      chk("lit_stream_word", 32'(instrucao), 32'h0000A000 + 32'(k % 16));
    end

    // Reset, then hold off consumption: queue fills and PC stops at 4.
    rst = 1'b1; step();
    rst = 1'b0; consumir = 1'b0;
    repeat (10) step();
    chk("lit_full_occ", 32'(ocupacao), 32'd4);
    chk("lit_full_pc", 32'(mem_endereco), 32'd4);
    chk("lit_full_head", 32'(instrucao), 32'h0000A000);

    // Redirect to 9 with a full queue and Consumir high.
    consumir = 1'b1; desvio = 1'b1; endereco_desvio = 4'd9;
    step();
    desvio = 1'b0;
    chk("lit_redir_occ", 32'(ocupacao), 32'd0);
    chk("lit_redir_addr", 32'(mem_endereco), 32'd9);
    step();
    chk("lit_redir_r2_valid", 32'(instrucao_valida), 32'h0);
    step();
    chk("lit_redir_head", 32'(instrucao), 32'h0000A009);
    chk("lit_redir_pc", 32'(pc_instrucao), 32'd9);

    // Redirect while the first target read is in flight: that word is dropped.
    desvio = 1'b1; endereco_desvio = 4'd5;
    step();
    endereco_desvio = 4'd12;
    step();
    desvio = 1'b0;
    step(); step();
    chk("lit_pend_drop_head", 32'(instrucao), 32'h0000A00C);
    step();
    chk("lit_pend_drop_next", 32'(pc_instrucao), 32'd13);

    // Mid-stream reset with three queued entries.
    rst = 1'b1; step();
    rst = 1'b0; consumir = 1'b0;
    repeat (4) step();
    chk("lit_occ3", 32'(ocupacao), 32'd3);
    rst = 1'b1; step();
    chk("lit_rst_addr", 32'(mem_endereco), 32'd0);
    chk("lit_rst_occ", 32'(ocupacao), 32'd0);
    chk("lit_rst_valid", 32'(instrucao_valida), 32'd0);
    chk("lit_rst_word", 32'(instrucao), 32'd0);
    chk("lit_rst_pc", 32'(pc_instrucao), 32'd0);
    rst = 1'b0;
    step(); step();
    chk("lit_restart_head", 32'(instrucao), 32'h0000A000);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int i = 0; i < 600; i++) begin
      consumir        = ($urandom_range(0, 9) < 6);
      desvio          = ($urandom_range(0, 99) < 8);
      endereco_desvio = ADDR_W'($urandom_range(0, 15));
      rst             = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0; desvio = 1'b0; consumir = 1'b0;
    step();
    en_cmp = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fila_de_instrucoes_bufferizada
`default_nettype wire
